sccb_slave: RTL and testbench
=============================

SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 SHALL have parameter DEVID, default 7'h21, meaning the 7-bit device ID; write ID is 8'h42, read ID is 8'h43.
REQ-002 SHALL have parameter FILT, default 3, meaning the number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port SCL, input, 1 bit: bus clock from the master, asynchronous to CLK.
REQ-006 SHALL have port SDA, inout, 1 bit: bus data; the block drives only 1'b0 or 1'bz.
REQ-007 SHALL have port REG_ADDR, output, 8 bits: latched sub-address.
REQ-008 SHALL have port REG_WDATA, output, 8 bits: latched write data.
REQ-009 SHALL have port REG_WE, output, 1 bit: one-CLK write strobe.
REQ-010 SHALL have port RD_DATA, input, 8 bits: register value for the addressed REG_ADDR, supplied by the user.
REQ-011 SHALL have port BUSY, output, 1 bit: high from an accepted START until STOP.

Function
REQ-012 SHALL pass SCL and SDA through 2-FF synchronizers, then a FILT-sample glitch filter; all following requirements refer to the filtered levels.
REQ-013 SHALL detect START as filtered SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1; edge detection is on filtered SCL (rise/fall one-CLK pulses).
REQ-014 SHALL sample SDA on the SCL rise pulse and change its own SDA drive only on the SCL fall pulse.
REQ-015 SHALL implement states IDLE, DEVADR, DEVACK, SUBADR, SUBACK, WDATA, WDACK, RDBYTE, RDACK, IGNORE.
REQ-016 SHALL enter DEVADR from any state on START, including a repeated START; the bit counter clears to 0.
REQ-017 SHALL enter IDLE from any state on STOP and release SDA.
REQ-018 In DEVADR, after 8 bits SHALL go to DEVACK if bits[7:1]==DEVID; otherwise SHALL go to IGNORE without driving ACK.
REQ-019 In DEVACK SHALL drive SDA=0 from the SCL fall after bit 8 until the next SCL fall; then go to SUBADR if R/W=0, or RDBYTE if R/W=1.
REQ-020 When entering RDBYTE SHALL latch RD_DATA into the read shifter on the DEVACK-ending SCL fall, and present the MSB immediately.
REQ-021 SHALL capture REG_ADDR after 8 SUBADR bits, then ACK in SUBACK and go to WDATA; a STOP here ends a 2-phase write that leaves REG_ADDR set for a later read.
REQ-022 SHALL capture REG_WDATA after 8 WDATA bits and pulse REG_WE for exactly one CLK on the SCL rise pulse of bit 8; it SHALL then ACK in WDACK and go to IGNORE (no address auto-increment; further bytes get no ACK).
REQ-023 In RDBYTE SHALL drive SDA=0 for a data bit of 0 and z for 1, advancing on each SCL fall for 8 bits; the 9th bit is RDACK, where SDA is released, the master's NA is ignored, and the next state is IGNORE.
REQ-024 In IGNORE SHALL keep SDA released and wait for START or STOP.
REQ-025 SHALL count exactly 8 bits per byte using a 3-bit wrap-around counter, with the wrap marking the byte end.
REQ-026 SHALL cancel a byte in progress on START or STOP mid-byte: no REG_WE, REG_ADDR/REG_WDATA unchanged.
REQ-027 SHALL drive BUSY=1 from the START detect until STOP detect, including during IGNORE.

Reset
REQ-028 On RST SHALL set state=IDLE, SDA=z, REG_ADDR=8'h00, REG_WDATA=8'h00, REG_WE=0, BUSY=0, and synchronizer and filter flops to 1.
REQ-029 RST asserted mid-transfer SHALL abort it with no REG_WE; after release, the block ignores the bus until the next START.

Verification
REQ-030 3-phase write 42/3A/55 at 100 kHz SHALL give three ACK low pulses, REG_ADDR=8'h3A, REG_WDATA=8'h55, and exactly one REG_WE pulse.
REQ-031 Write 44/3A/55 (wrong ID) SHALL leave SDA z throughout, with no REG_WE and REG_ADDR unchanged.
REQ-032 2-phase write 42/12 + STOP, then 43 with RD_DATA=8'hA5, SHALL return 1010_0101 MSB first, with SDA released on the 9th bit.
REQ-033 STOP after 4 bits of WDATA SHALL give no REG_WE, IDLE, and BUSY=0.
REQ-034 A 1-CLK SDA glitch while SCL=1 (FILT=3) SHALL cause no START/STOP detect and no state change.
REQ-035 Repeated START after SUBACK, followed by 43, SHALL read RD_DATA for the newly latched REG_ADDR.

Source files
------------

// File: rtl/sccb_slave.sv
// SCCB (I2C-like) register-access slave: write ID/sub-address/data and single-byte reads.
// SCL/SDA are synchronised and glitch-filtered; all protocol decoding uses the filtered levels.
module sccb_slave #(
  parameter logic [6:0] DEVID = 7'h21,
  parameter int         FILT  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  typedef enum logic [3:0] {
    IDLE, DEVADR, DEVACK, SUBADR, SUBACK, WDATA, WDACK, RDBYTE, RDACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  // Bit 1 carries SCL, bit 0 carries SDA through the synchroniser and filter.
  logic [1:0]          sync1, sync2, filt, filt_q;
  logic [1:0][CW-1:0]  cnt;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] rd_shift;
  logic       rw_q;
  logic       ack_low;

  logic       scl_rise, scl_fall, start_det, stop_det, byte_end;
  logic [7:0] rx_byte;
  logic       sda_drive;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_q <= '1;
      cnt    <= '0;
    end else begin
      sync1  <= {SCL, SDA};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise  =  filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] &  filt_q[1];
  assign start_det =  filt[1] &  filt_q[1] &  filt_q[0] & ~filt[0];
  assign stop_det  =  filt[1] &  filt_q[1] & ~filt_q[0] &  filt[0];
  assign rx_byte   = {shift, filt[0]};
  assign byte_end  = scl_rise & (bit_cnt == 3'd7);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = DEVADR;
    end else begin
      case (state_q)
        DEVADR: if (byte_end) state_d = (rx_byte[7:1] == DEVID) ? DEVACK : IGNORE;
        DEVACK: if (scl_fall && ack_low) state_d = rw_q ? RDBYTE : SUBADR;
        SUBADR: if (byte_end) state_d = SUBACK;
        SUBACK: if (scl_fall && ack_low) state_d = WDATA;
        WDATA:  if (byte_end) state_d = WDACK;
        WDACK:  if (scl_fall && ack_low) state_d = IGNORE;
        RDBYTE: if (scl_fall && bit_cnt == 3'd7) state_d = RDACK;
        RDACK:  if (scl_rise) state_d = IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt   <= '0;
      shift     <= '0;
      rd_shift  <= '1;
      rw_q      <= 1'b0;
      ack_low   <= 1'b0;
      REG_ADDR  <= 8'h00;
      REG_WDATA <= 8'h00;
      REG_WE    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      REG_WE <= 1'b0;
      if (stop_det) begin
        BUSY    <= 1'b0;
        bit_cnt <= '0;
        ack_low <= 1'b0;
      end else if (start_det) begin
        BUSY    <= 1'b1;
        bit_cnt <= '0;
        ack_low <= 1'b0;
      end else begin
        case (state_q)
          DEVADR, SUBADR, WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state_q == DEVADR) rw_q     <= filt[0];
                if (state_q == SUBADR) REG_ADDR <= rx_byte;
                if (state_q == WDATA) begin
                  REG_WDATA <= rx_byte;
                  REG_WE    <= 1'b1;
                end
              end
            end
          end
          // First fall asserts ACK, second fall releases it; the read byte is loaded on that release.
          DEVACK, SUBACK, WDACK: begin
            if (scl_fall) begin
              ack_low <= ~ack_low;
              if (ack_low) rd_shift <= RD_DATA;
            end
          end
          RDBYTE: begin
            if (scl_fall) begin
              bit_cnt  <= bit_cnt + 3'd1;
              rd_shift <= {rd_shift[6:0], 1'b1};
            end
          end
          default: ack_low <= 1'b0;
        endcase
      end
    end
  end

  assign sda_drive = ack_low | ((state_q == RDBYTE) & ~rd_shift[7]);
  assign SDA       = sda_drive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master at 100 kHz (CLK 4 MHz), vector table,
// hand-written corner sequences and randomized transactions against a rule-level model.
`timescale 1ns/1ps
module tb_sccb_slave;

  localparam int Q = 10;  // CLK cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, rd_data;
  logic       reg_we, busy;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;
  int we_cycles = 0;
  int ack_pulses = 0;
  logic dut_low, dut_low_q = 1'b0;

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    logic            rd;
    logic [3:0]      exp_ack;
    logic [7:0]      exp_addr;
    logic [7:0]      exp_wdata;
    logic [7:0]      exp_rd;
    int              exp_we;
    int              exp_pulses;
  } vec_t;

  vec_t vecs [7];

  always #125 clk = ~clk;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign rd_data = mem[reg_addr];

  sccb_slave #(.DEVID(7'h21), .FILT(3)) dut (
    .CLK(clk), .RST(rst), .SCL(m_scl), .SDA(sda),
    .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we),
    .RD_DATA(rd_data), .BUSY(busy)
  );

  // Counts REG_WE high cycles and slave-driven low pulses (bus low while the master releases).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reg_we) we_cycles++;
      dut_low = (sda === 1'b0) && m_sda;
      if (dut_low && !dut_low_q) ack_pulses++;
      dut_low_q = dut_low;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not complete");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic clock_bit(input logic b, input logic glitch, output logic seen);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    seen = sda;
    if (glitch) begin
      m_sda = ~b; wait_clk(1);
      m_sda = b;  wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], gmask[i], s);
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic released);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(1'b1, 1'b0, s);
    released = s;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int we0, p0;
    logic a, rel;
    logic [7:0] d;
    we0 = we_cycles;
    p0  = ack_pulses;
    start_cond();
    for (int i = 0; i < v.n; i++) begin
      write_byte(v.b[i], 8'h00, a);
      check($sformatf("vec%0d ack%0d", idx, i), {31'd0, a}, {31'd0, v.exp_ack[i]});
    end
    if (v.rd) begin
      read_byte(d, rel);
      check($sformatf("vec%0d rdata", idx), {24'd0, d}, {24'd0, v.exp_rd});
      check($sformatf("vec%0d sda_released_9th", idx), {31'd0, rel}, 32'd1);
    end
    stop_cond();
    check($sformatf("vec%0d reg_addr", idx), {24'd0, reg_addr}, {24'd0, v.exp_addr});
    check($sformatf("vec%0d reg_wdata", idx), {24'd0, reg_wdata}, {24'd0, v.exp_wdata});
    check($sformatf("vec%0d we_cycles", idx), we_cycles - we0, v.exp_we);
    check($sformatf("vec%0d slave_low_pulses", idx), ack_pulses - p0, v.exp_pulses);
    check($sformatf("vec%0d busy_after_stop", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int we0;
    logic a, rel;
    logic [7:0] d, pat;
    logic [7:0] m_addr, m_wdata;
    int m_we, we_base;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      mem[i] = {v[3:0], v[7:4]};
    end
    mem[8'h12] = 8'hA5;

    // {bytes (first in low byte), n, read, ack mask, addr, wdata, read data, we cycles, slave pulses}
    vecs[0] = '{32'h00553A42, 3, 1'b0, 4'b0111, 8'h3A, 8'h55, 8'h00, 1, 3};
    vecs[1] = '{32'h00997E44, 3, 1'b0, 4'b0000, 8'h3A, 8'h55, 8'h00, 0, 0};
    vecs[2] = '{32'h00001242, 2, 1'b0, 4'b0011, 8'h12, 8'h55, 8'h00, 0, 2};
    vecs[3] = '{32'h00000043, 1, 1'b1, 4'b0001, 8'h12, 8'h55, 8'hA5, 0, 4};
    vecs[4] = '{32'h77C30542, 4, 1'b0, 4'b0111, 8'h05, 8'hC3, 8'h00, 1, 3};
    vecs[5] = '{32'h00000043, 1, 1'b1, 4'b0001, 8'h05, 8'hC3, 8'h50, 0, 3};
    vecs[6] = '{32'h00000045, 1, 1'b1, 4'b0000, 8'h05, 8'hC3, 8'hFF, 0, 0};

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2 * Q);
    check("reset reg_addr", {24'd0, reg_addr}, 32'h00);
    check("reset reg_wdata", {24'd0, reg_wdata}, 32'h00);
    check("reset we_cycles", we_cycles, 0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset sda", {31'd0, sda}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Repeated START after SUBACK, then read from the freshly latched address.
    we0 = we_cycles;
    start_cond();
    write_byte(8'h42, 8'h00, a); check("rs ack_dev", {31'd0, a}, 32'd1);
    write_byte(8'h1E, 8'h00, a); check("rs ack_sub", {31'd0, a}, 32'd1);
    start_cond();
    write_byte(8'h43, 8'h00, a); check("rs ack_rd", {31'd0, a}, 32'd1);
    read_byte(d, rel);
    check("rs rdata", {24'd0, d}, 32'hE1);
    stop_cond();
    check("rs reg_addr", {24'd0, reg_addr}, 32'h1E);
    check("rs we_cycles", we_cycles - we0, 0);

    // STOP after four WDATA bits cancels the byte.
    we0 = we_cycles;
    pat = 8'h55;
    start_cond();
    write_byte(8'h42, 8'h00, a);
    write_byte(8'h3A, 8'h00, a);
    for (int i = 7; i >= 4; i--) clock_bit(pat[i], 1'b0, rel);
    stop_cond();
    check("midstop we_cycles", we_cycles - we0, 0);
    check("midstop busy", {31'd0, busy}, 32'd0);
    check("midstop reg_wdata", {24'd0, reg_wdata}, 32'hC3);
    check("midstop reg_addr", {24'd0, reg_addr}, 32'h3A);

    // One-CLK SDA glitches while SCL is high: idle bus, then inside a sub-address byte.
    m_sda = 1'b0; wait_clk(1);
    m_sda = 1'b1; wait_clk(2 * Q);
    check("glitch idle busy", {31'd0, busy}, 32'd0);
    we0 = we_cycles;
    start_cond();
    write_byte(8'h42, 8'h00, a);
    write_byte(8'h6C, 8'hC0, a);
    check("glitch sub ack", {31'd0, a}, 32'd1);
    check("glitch busy held", {31'd0, busy}, 32'd1);
    write_byte(8'h9A, 8'h00, a);
    stop_cond();
    check("glitch reg_addr", {24'd0, reg_addr}, 32'h6C);
    check("glitch reg_wdata", {24'd0, reg_wdata}, 32'h9A);
    check("glitch we_cycles", we_cycles - we0, 1);

    // Reset in the middle of a data byte aborts the write; the rest of the frame is ignored.
    we0 = we_cycles;
    start_cond();
    write_byte(8'h42, 8'h00, a);
    write_byte(8'h3A, 8'h00, a);
    for (int i = 7; i >= 4; i--) clock_bit(pat[i], 1'b0, rel);
    rst = 1'b1; wait_clk(3);
    check("rst_mid reg_addr", {24'd0, reg_addr}, 32'h00);
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid sda", {31'd0, sda}, 32'd1);
    rst = 1'b0; wait_clk(2);
    for (int i = 3; i >= 0; i--) clock_bit(pat[i], 1'b0, rel);
    clock_bit(1'b1, 1'b0, rel);
    check("rst_mid no_ack", {31'd0, rel}, 32'd1);
    stop_cond();
    check("rst_mid we_cycles", we_cycles - we0, 0);
    check("rst_mid reg_wdata", {24'd0, reg_wdata}, 32'h00);

    // Randomized transactions against a rule-level model of the register interface.
    m_addr = 8'h00; m_wdata = 8'h00; m_we = 0; we_base = we_cycles;
    for (int t = 0; t < 25; t++) begin
      int kind, n;
      logic [7:0] tx [4];
      logic [6:0] w;
      logic match;
      kind = int'($urandom_range(0, 2));
      start_cond();
      if (kind == 2) begin
        write_byte(8'h43, 8'h00, a);
        check($sformatf("rand%0d rd ack", t), {31'd0, a}, 32'd1);
        read_byte(d, rel);
        check($sformatf("rand%0d rdata", t), {24'd0, d}, {24'd0, mem[m_addr]});
      end else begin
        n = int'($urandom_range(2, 4));
        if (kind == 0) begin
          tx[0] = 8'h42;
        end else begin
          w = 7'($urandom);
          while (w == 7'h21) w = 7'($urandom);
          tx[0] = {w, 1'b0};
        end
        for (int i = 1; i < 4; i++) tx[i] = 8'($urandom);
        match = (tx[0][7:1] == 7'h21);
        for (int i = 0; i < n; i++) begin
          write_byte(tx[i], 8'h00, a);
          check($sformatf("rand%0d ack%0d", t, i), {31'd0, a}, {31'd0, match && (i < 3)});
        end
        if (match) begin
          m_addr = tx[1];
          if (n >= 3) begin
            m_wdata = tx[2];
            m_we++;
          end
        end
      end
      stop_cond();
      check($sformatf("rand%0d reg_addr", t), {24'd0, reg_addr}, {24'd0, m_addr});
      check($sformatf("rand%0d reg_wdata", t), {24'd0, reg_wdata}, {24'd0, m_wdata});
      check($sformatf("rand%0d we_cycles", t), we_cycles - we_base, m_we);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
